// File: rtl/lc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc_pkg
//  Description : Shared definitions for the level-crossing axle counter:
//                decoder state encoding, detector offsets within a track
//                island and the timeout counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lc_pkg;

    // Direction decoder states (3-bit encoding)
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] A1       = 3'd1;
    localparam logic [2:0] A2       = 3'd2;
    localparam logic [2:0] A3       = 3'd3;
    localparam logic [2:0] B1       = 3'd4;
    localparam logic [2:0] B2       = 3'd5;
    localparam logic [2:0] B3       = 3'd6;
    localparam logic [2:0] WAIT_CLR = 3'd7;

    // Detector offset within a track island: detector 2t+offset
    localparam int DET_ENTRY = 0;
    localparam int DET_EXIT  = 1;

    // Width needed to hold a count up to timeout_cyc
    function automatic int tmo_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc_axle_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : lc_axle_decoder
//  Description : One detector point: 2-flop synchronisers and debounce on
//                both rail sensors, direction FSM with backtrack tolerance,
//                and a stall timeout that forces WAIT_CLR and flags a fault.
//  Revision    : 1.0  initial release
// ============================================================================
module lc_axle_decoder
    import lc_pkg::*;
#(
    parameter int DEB_CYC     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sens_a,
    input  logic sens_b,
    output logic a2b,
    output logic b2a,
    output logic timeout_flt
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = tmo_width(TIMEOUT_CYC);
    localparam logic [DW-1:0] C_DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    // Index 1 = sensor A, index 0 = sensor B, so w_filt reads as {a,b}
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {sens_a, sens_b};

    for (genvar i = 0; i < 2; i++) begin : g_sens
        logic          r_meta;
        logic          r_sync;
        logic          r_filt;
        logic [DW-1:0] r_deb_cnt;

        // Synchronise, then accept a level change only after DEB_CYC steady samples
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_meta    <= 1'b0;
                r_sync    <= 1'b0;
                r_filt    <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_meta <= w_raw[i];
                r_sync <= r_meta;
                if (r_sync == r_filt) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == C_DEB_LAST) begin
                    r_filt    <= r_sync;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end

        assign w_filt[i] = r_filt;
    end

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_tmo;
    logic          r_a2b;
    logic          r_b2a;
    logic          r_tflt;

    // Next-state decode on the filtered sensor pair
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_filt == 2'b10) w_next = A1;
                      else if (w_filt == 2'b01) w_next = B1;
                      else if (w_filt == 2'b11) w_next = WAIT_CLR;
            A1:       if (w_filt == 2'b11) w_next = A2;
                      else if (w_filt == 2'b00) w_next = IDLE;
            A2:       if (w_filt == 2'b01) w_next = A3;
                      else if (w_filt == 2'b10) w_next = A1;
            A3:       if (w_filt == 2'b00) w_next = IDLE;
                      else if (w_filt == 2'b11) w_next = A2;
            B1:       if (w_filt == 2'b11) w_next = B2;
                      else if (w_filt == 2'b00) w_next = IDLE;
            B2:       if (w_filt == 2'b10) w_next = B3;
                      else if (w_filt == 2'b01) w_next = B1;
            B3:       if (w_filt == 2'b00) w_next = IDLE;
                      else if (w_filt == 2'b11) w_next = B2;
            WAIT_CLR: if (w_filt == 2'b00) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // State register, stall timer and registered single-cycle pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_a2b   <= 1'b0;
            r_b2a   <= 1'b0;
            r_tflt  <= 1'b0;
        end else begin
            r_a2b  <= 1'b0;
            r_b2a  <= 1'b0;
            r_tflt <= 1'b0;
            if (r_state == IDLE) begin
                r_tmo   <= '0;
                r_state <= w_next;
            end else if (w_next != r_state) begin
                r_tmo   <= '0;
                r_state <= w_next;
                r_a2b   <= (r_state == A3) && (w_next == IDLE);
                r_b2a   <= (r_state == B3) && (w_next == IDLE);
            end else if (r_tmo == C_TMO_LAST) begin
                // Stalled too long: abandon the passage without a pulse
                r_tmo   <= '0;
                r_state <= WAIT_CLR;
                r_tflt  <= 1'b1;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign a2b         = r_a2b;
    assign b2a         = r_b2a;
    assign timeout_flt = r_tflt;

endmodule
`default_nettype wire

// File: rtl/lc_axle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lc_axle_counter
//  Description : Multi-island axle counter. Two decoders per track island
//                (entry, exit) feed a saturating occupancy count, a sticky
//                per-track fault and a registered crossing gate request.
//  Revision    : 1.0  initial release
// ============================================================================
module lc_axle_counter
    import lc_pkg::*;
#(
    parameter int NUM_TRK     = 2,
    parameter int CNT_W       = 6,
    parameter int DEB_CYC     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [2*NUM_TRK-1:0]     sens_a,
    input  logic [2*NUM_TRK-1:0]     sens_b,
    input  logic                     clear_fault,
    output logic [2*NUM_TRK-1:0]     a2b,
    output logic [2*NUM_TRK-1:0]     b2a,
    output logic [NUM_TRK*CNT_W-1:0] occ_cnt,
    output logic [NUM_TRK-1:0]       occupied,
    output logic [NUM_TRK-1:0]       fault,
    output logic                     gate_close
);

    localparam int ND = 2 * NUM_TRK;
    localparam int SW = CNT_W + 2;

    logic [ND-1:0] w_tflt;
    logic          r_gate;

    for (genvar d = 0; d < ND; d++) begin : g_det
        lc_axle_decoder #(
            .DEB_CYC     (DEB_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_dec (
            .Clk         (Clk),
            .Reset       (Reset),
            .sens_a      (sens_a[d]),
            .sens_b      (sens_b[d]),
            .a2b         (a2b[d]),
            .b2a         (b2a[d]),
            .timeout_flt (w_tflt[d])
        );
    end

    for (genvar t = 0; t < NUM_TRK; t++) begin : g_trk
        localparam int ENT = 2 * t + DET_ENTRY;
        localparam int EXT = 2 * t + DET_EXIT;

        logic [CNT_W-1:0] r_cnt;
        logic             r_fault;
        logic [SW-1:0]    w_sum;
        logic             w_neg;
        logic             w_ovf;

        // Net change of all four events; two guard bits catch under/overflow
        always_comb begin
            w_sum = {2'b00, r_cnt} + SW'(a2b[ENT]) + SW'(b2a[EXT])
                                   - SW'(b2a[ENT]) - SW'(a2b[EXT]);
            w_neg = w_sum[SW-1];
            w_ovf = !w_sum[SW-1] && w_sum[CNT_W];
        end

        // Saturating occupancy count and sticky fault (set wins over clear)
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cnt   <= '0;
                r_fault <= 1'b0;
            end else begin
                if (w_neg)
                    r_cnt <= '0;
                else if (w_ovf)
                    r_cnt <= {CNT_W{1'b1}};
                else
                    r_cnt <= w_sum[CNT_W-1:0];
                r_fault <= (r_fault && !clear_fault) || w_neg || w_ovf
                           || w_tflt[ENT] || w_tflt[EXT];
            end
        end

        assign occ_cnt[t*CNT_W +: CNT_W] = r_cnt;
        assign occupied[t]               = |r_cnt;
        assign fault[t]                  = r_fault;
    end

    // Gate request follows any occupancy or fault one cycle later
    always_ff @(posedge Clk) begin
        if (Reset)
            r_gate <= 1'b0;
        else
            r_gate <= (|occupied) || (|fault);
    end

    assign gate_close = r_gate;

endmodule
`default_nettype wire

// File: doc/lc_axle_counter.md
Name: lc_axle_counter

Overview:
Parametrised successor to the single-pair wheel-direction FSM. Each detector point has two rail sensors (a, b). Per detector, the block does:
- input synchronisation
- debounce
- direction decode with backtrack tolerance and a stall timeout.
Detectors are grouped into NUM_TRK track islands, each with an entry and an exit detector. The block keeps a per-island axle occupancy count and drives the crossing gate-close request.

Parameters:
NUM_TRK, 2, number of track islands; detector 2t = entry of track t, detector 2t+1 = exit
CNT_W, 6, width of per-track axle occupancy counter (unsigned, saturating)
DEB_CYC, 4, consecutive equal synchronised samples required to accept a sensor level change; must be >= 1
TIMEOUT_CYC, 1000, cycles a decoder may remain in a non-IDLE state without a state change before it faults

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
sens_a  in  2*NUM_TRK  raw sensor A per detector (asynchronous)
sens_b  in  2*NUM_TRK  raw sensor B per detector (asynchronous)
clear_fault  in  1  synchronous; clears all fault flags
a2b  out  2*NUM_TRK  one-cycle pulse: axle passed A->B at detector
b2a  out  2*NUM_TRK  one-cycle pulse: axle passed B->A at detector
occ_cnt  out  NUM_TRK*CNT_W  packed per-track axle count, track t at [t*CNT_W +: CNT_W]
occupied  out  NUM_TRK  occ_cnt of track != 0
fault  out  NUM_TRK  sticky track fault
gate_close  out  1  OR of all occupied and all fault bits, registered

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - all outputs 0; occ_cnt 0; decoders IDLE
  - sync flops, filtered levels and debounce/timeout counters 0
- Input path per sensor: 2-flop synchroniser, then debounce filter.
  - Filter counter increments while the sync output differs from the filtered level; it clears when they are equal.
  - The filtered level toggles on the edge where the count reaches DEB_CYC.
  - A glitch shorter than DEB_CYC cycles never reaches the decoder.
- Decoder FSM per detector, on the filtered pair {a,b}:
  - IDLE: 10->A1, 01->B1, else stay.
  - A1: 11->A2, 00->IDLE, else stay.
  - A2: 01->A3, 10->A1, else stay.
  - A3: 00->IDLE with a2b pulse, 11->A2, else stay.
  - B1: 11->B2, 00->IDLE, else stay.
  - B2: 10->B3, 01->B1, else stay.
  - B3: 00->IDLE with b2a pulse, 11->B2, else stay.
  - 11 directly from IDLE -> WAIT_CLR.
  - WAIT_CLR: 00->IDLE, else stay; no pulse.
- Pulses are registered and asserted for exactly 1 cycle, in the cycle the FSM enters IDLE.
- Latency: from the raw final falling edge, the pulse is high DEB_CYC+3 edges later, provided the input is held stable.
- Timeout:
  - The timeout counter clears on every state change and while the decoder is in IDLE.
  - When it reaches TIMEOUT_CYC in any other state: the owning track's fault is set, the decoder goes to WAIT_CLR, and no pulse is generated.
- Occupancy per track t, counting +1/-1 events:
  - +1: entry a2b, exit b2a
  - -1: entry b2a, exit a2b
- Occupancy arithmetic:
  - All four events in one cycle are summed; the net change is applied once.
  - Counter saturates: if net result > 2^CNT_W-1, hold at max and set fault; if net result < 0, hold at 0 and set fault.
  - occ_cnt updates the cycle after the pulse; occupied is combinational from the count.
- Fault:
  - Sticky until clear_fault=1 on an edge.
  - If a new fault condition and clear_fault occur in the same cycle, the fault remains set.
  - clear_fault does not alter occ_cnt.
- gate_close: registered, updated one cycle after occupied or fault change.
- Reset mid-passage: the decoder returns to IDLE, partial sequences are discarded, counts return to 0.

Decomposition:
- Shared package lc_pkg holds:
  - decoder state encoding (IDLE, A1..A3, B1..B3, WAIT_CLR; 3-bit)
  - DET_ENTRY=0, DET_EXIT=1 offsets
  - helper function for timeout counter width, $clog2(TIMEOUT_CYC+1)
- Sub-module lc_axle_decoder, one per detector, generate-instantiated 2*NUM_TRK times.
  - Contains: synchroniser, debounce, FSM, timeout.
  - Outputs: a2b, b2a, timeout_flt.
- The top level holds the occupancy counters, fault flags and gate_close.

Test Plan:
1. Reset, then entry detector 0 sequence 10,11,01,00, each held 10 cycles (NUM_TRK=2, CNT_W=4, DEB_CYC=2, TIMEOUT_CYC=50) -> single a2b[0] pulse 5 edges after the final 00; occ_cnt[3:0]=1; gate_close=1 one cycle later.
2. Backtrack on detector 0: 10,11,10,00 -> no pulse, count unchanged. Then 1-cycle glitch 10 while IDLE -> filtered input unchanged, no state change.
3. Three entry a2b passages on track 0, then three exit a2b passages (detector 1) -> count 3 then 0, occupied[0]=0, gate_close falls one cycle after.
4. Exit a2b on track 1 with count 0 -> count stays 0, fault[1]=1, gate_close=1. Then clear_fault -> fault[1]=0, gate_close=0.
5. Detector 2 held at 10 for 60 cycles -> fault[1] set at timeout, decoder in WAIT_CLR. Release to 00 -> no pulse, count unchanged.
6. Entry a2b and exit a2b pulses in the same cycle at count 5 -> count stays 5. 16 entries from 0 with CNT_W=4 -> saturates at 15 with fault. Reset asserted mid-sequence -> all outputs 0.
